// File: rtl/checkpoint_alloc_ctrl.sv
// ---------------------------------------------------------------------------
// checkpoint_alloc_ctrl
//
// Allocation controller for the rename checkpoint array. Slots are handed out
// in age order from a circular buffer (tail = youngest, head = oldest). The
// oldest slot is freed when its branch retires. A mispredict rolls the tail
// back to the mispredicted branch's slot and issues a one-cycle restore
// command to the checkpoint array / map table.
//
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   save_valid/rob_index  rename requests a checkpoint for a branch
//   save_ready            a free slot exists
//   save_index            slot granted (tail index)
//   save_fire             write-enable to the array at save_index
//   restore_valid/index   mispredict restore request and target slot
//   restore_fire          registered restore command (1-cycle pulse)
//   restore_read_index    slot the array must read for the restore
//   restore_error         registered pulse: last restore hit a non-live slot
//   free_valid/index      retire frees the oldest checkpoint
//   head_index            oldest live slot
//   head_rob_index        ROB index stored in the head slot (stale if empty)
//   checkpoint_count      number of live slots
//   checkpoint_scarce     free slots at or below CHECKPOINT_THRESHOLD
// ---------------------------------------------------------------------------
module checkpoint_alloc_ctrl #(
    parameter int CHECKPOINT_COUNT       = 8,
    parameter int CHECKPOINT_INDEX_WIDTH = 3,
    parameter int CHECKPOINT_THRESHOLD   = 3,
    parameter int LOG_ROB_ENTRIES        = 7
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              save_valid,
    input  logic [LOG_ROB_ENTRIES-1:0]        save_rob_index,
    output logic                              save_ready,
    output logic [CHECKPOINT_INDEX_WIDTH-1:0] save_index,
    output logic                              save_fire,
    input  logic                              restore_valid,
    input  logic [CHECKPOINT_INDEX_WIDTH-1:0] restore_index,
    output logic                              restore_fire,
    output logic [CHECKPOINT_INDEX_WIDTH-1:0] restore_read_index,
    output logic                              restore_error,
    input  logic                              free_valid,
    input  logic [CHECKPOINT_INDEX_WIDTH-1:0] free_index,
    output logic [CHECKPOINT_INDEX_WIDTH-1:0] head_index,
    output logic [LOG_ROB_ENTRIES-1:0]        head_rob_index,
    output logic [CHECKPOINT_INDEX_WIDTH:0]   checkpoint_count,
    output logic                              checkpoint_scarce
);

    localparam int PW = CHECKPOINT_INDEX_WIDTH + 1;
    localparam logic [PW-1:0] FULL_COUNT   = PW'(CHECKPOINT_COUNT);
    localparam logic [PW-1:0] SCARCE_LIMIT = PW'(CHECKPOINT_THRESHOLD);
    localparam logic [PW-1:0] PTR_ONE      = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] PTR_ZERO     = {PW{1'b0}};

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0]                     head_ptr_r;
    logic [PW-1:0]                     tail_ptr_r;
    logic [PW-1:0]                     head_ptr_next_s;
    logic [PW-1:0]                     tail_ptr_next_s;
    logic [PW-1:0]                     count_s;
    logic [PW-1:0]                     free_slots_s;
    logic [CHECKPOINT_INDEX_WIDTH-1:0] age_s;
    logic                              restore_accept_s;
    logic                              free_fire_s;
    logic                              restore_fire_r;
    logic                              restore_error_r;
    logic [CHECKPOINT_INDEX_WIDTH-1:0] restore_read_index_r;
    logic [LOG_ROB_ENTRIES-1:0]        rob_index_array_r [CHECKPOINT_COUNT];

    assign count_s      = tail_ptr_r - head_ptr_r;
    assign free_slots_s = FULL_COUNT - count_s;
    assign save_index   = tail_ptr_r[CHECKPOINT_INDEX_WIDTH-1:0];
    assign head_index   = head_ptr_r[CHECKPOINT_INDEX_WIDTH-1:0];

    // save_ready deliberately ignores restore_valid; the restore only gates save_fire.
    assign save_ready  = (count_s != FULL_COUNT);
    assign save_fire   = save_valid & save_ready & ~restore_valid;
    assign free_fire_s = free_valid & (count_s != PTR_ZERO) & (free_index == head_index);

    // Age of the restore target relative to the oldest slot; live iff age < count.
    assign age_s            = restore_index - head_index;
    assign restore_accept_s = restore_valid & ({1'b0, age_s} < count_s);

    assign checkpoint_count   = count_s;
    assign checkpoint_scarce  = (free_slots_s <= SCARCE_LIMIT);
    assign head_rob_index     = rob_index_array_r[head_index];
    assign restore_fire       = restore_fire_r;
    assign restore_error      = restore_error_r;
    assign restore_read_index = restore_read_index_r;

    // Next-pointer selection: an accepted restore overrides any save.
    always_comb begin
        head_ptr_next_s = head_ptr_r;
        tail_ptr_next_s = tail_ptr_r;
        if (restore_accept_s) begin
            // Tail is based on the old head; a same-cycle free of the restored
            // slot itself (age 0) is dropped so the result is simply empty.
            tail_ptr_next_s = head_ptr_r + {1'b0, age_s};
            if (free_fire_s && (age_s != {CHECKPOINT_INDEX_WIDTH{1'b0}})) begin
                head_ptr_next_s = head_ptr_r + PTR_ONE;
            end else begin
                head_ptr_next_s = head_ptr_r;
            end
        end else begin
            if (free_fire_s) begin
                head_ptr_next_s = head_ptr_r + PTR_ONE;
            end else begin
                head_ptr_next_s = head_ptr_r;
            end
            if (save_fire) begin
                tail_ptr_next_s = tail_ptr_r + PTR_ONE;
            end else begin
                tail_ptr_next_s = tail_ptr_r;
            end
        end
    end

    // Pointer registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            head_ptr_r <= PTR_ZERO;
            tail_ptr_r <= PTR_ZERO;
        end else begin
            head_ptr_r <= head_ptr_next_s;
            tail_ptr_r <= tail_ptr_next_s;
        end
    end

    // ROB index captured per slot when a checkpoint is granted.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < CHECKPOINT_COUNT; i++) begin
                rob_index_array_r[i] <= {LOG_ROB_ENTRIES{1'b0}};
            end
        end else if (save_fire) begin
            rob_index_array_r[save_index] <= save_rob_index;
        end
    end

    // Registered restore command and error pulses; reset cancels a pending pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            restore_fire_r       <= 1'b0;
            restore_error_r      <= 1'b0;
            restore_read_index_r <= {CHECKPOINT_INDEX_WIDTH{1'b0}};
        end else begin
            restore_fire_r  <= restore_accept_s;
            restore_error_r <= restore_valid & ~restore_accept_s;
            if (restore_accept_s) begin
                restore_read_index_r <= restore_index;
            end
        end
    end

endmodule

// File: tb/tb_checkpoint_alloc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_checkpoint_alloc_ctrl
//
// Directed test of checkpoint_alloc_ctrl: fill/full, head free and ignored
// free, pointer wrap, restore with dropped save, restore error, restore with
// simultaneous free, and reset during a restore.
// ---------------------------------------------------------------------------
module tb_checkpoint_alloc_ctrl;

    logic       CLK;
    logic       RST;
    logic       save_valid;
    logic [6:0] save_rob_index;
    logic       save_ready;
    logic [2:0] save_index;
    logic       save_fire;
    logic       restore_valid;
    logic [2:0] restore_index;
    logic       restore_fire;
    logic [2:0] restore_read_index;
    logic       restore_error;
    logic       free_valid;
    logic [2:0] free_index;
    logic [2:0] head_index;
    logic [6:0] head_rob_index;
    logic [3:0] checkpoint_count;
    logic       checkpoint_scarce;

    int n_compared;
    int n_mismatched;

    checkpoint_alloc_ctrl dut (
        .CLK                (CLK),
        .RST                (RST),
        .save_valid         (save_valid),
        .save_rob_index     (save_rob_index),
        .save_ready         (save_ready),
        .save_index         (save_index),
        .save_fire          (save_fire),
        .restore_valid      (restore_valid),
        .restore_index      (restore_index),
        .restore_fire       (restore_fire),
        .restore_read_index (restore_read_index),
        .restore_error      (restore_error),
        .free_valid         (free_valid),
        .free_index         (free_index),
        .head_index         (head_index),
        .head_rob_index     (head_rob_index),
        .checkpoint_count   (checkpoint_count),
        .checkpoint_scarce  (checkpoint_scarce)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        save_valid     = 1'b0;
        save_rob_index = 7'd0;
        restore_valid  = 1'b0;
        restore_index  = 3'd0;
        free_valid     = 1'b0;
        free_index     = 3'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic do_save(input logic [6:0] rob);
        save_valid     = 1'b1;
        save_rob_index = rob;
        tick();
        save_valid     = 1'b0;
    endtask

    task automatic do_free(input logic [2:0] idx);
        free_valid = 1'b1;
        free_index = idx;
        tick();
        free_valid = 1'b0;
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        RST          = 1'b1;
        idle_inputs();
        do_reset();

        // Reset state
        check_value("rst_count", 32'(checkpoint_count), 32'd0);
        check_value("rst_save_ready", 32'(save_ready), 32'd1);
        check_value("rst_save_index", 32'(save_index), 32'd0);
        check_value("rst_save_fire", 32'(save_fire), 32'd0);
        check_value("rst_restore_fire", 32'(restore_fire), 32'd0);
        check_value("rst_restore_rd_idx", 32'(restore_read_index), 32'd0);
        check_value("rst_restore_error", 32'(restore_error), 32'd0);
        check_value("rst_head_index", 32'(head_index), 32'd0);
        check_value("rst_head_rob", 32'(head_rob_index), 32'd0);
        check_value("rst_scarce", 32'(checkpoint_scarce), 32'd0);

        // Fill: 8 saves with rob 10..17
        for (int i = 0; i < 8; i++) begin
            save_valid     = 1'b1;
            save_rob_index = 7'(10 + i);
            #1;
            check_value("fill_save_index", 32'(save_index), 32'(i));
            check_value("fill_save_fire", 32'(save_fire), 32'd1);
            tick();
            save_valid = 1'b0;
            if (i == 3) check_value("scarce_after_4", 32'(checkpoint_scarce), 32'd0);
            if (i == 4) check_value("scarce_after_5", 32'(checkpoint_scarce), 32'd1);
        end
        check_value("full_count", 32'(checkpoint_count), 32'd8);
        check_value("full_save_ready", 32'(save_ready), 32'd0);
        check_value("full_head_rob", 32'(head_rob_index), 32'd10);
        save_valid     = 1'b1;
        save_rob_index = 7'd99;
        #1;
        check_value("full_save_fire", 32'(save_fire), 32'd0);
        tick();
        save_valid = 1'b0;
        check_value("full_count_hold", 32'(checkpoint_count), 32'd8);

        // Free the head, then an ignored non-head free
        do_free(3'd0);
        check_value("free_count", 32'(checkpoint_count), 32'd7);
        check_value("free_head_index", 32'(head_index), 32'd1);
        check_value("free_head_rob", 32'(head_rob_index), 32'd11);
        do_free(3'd3);
        check_value("badfree_count", 32'(checkpoint_count), 32'd7);
        check_value("badfree_head", 32'(head_index), 32'd1);

        // Save and free together: count unchanged, head advances
        save_valid     = 1'b1;
        save_rob_index = 7'd40;
        free_valid     = 1'b1;
        free_index     = 3'd1;
        #1;
        check_value("sf_save_fire", 32'(save_fire), 32'd1);
        check_value("sf_save_index", 32'(save_index), 32'd0);
        tick();
        idle_inputs();
        check_value("sf_count", 32'(checkpoint_count), 32'd7);
        check_value("sf_head_index", 32'(head_index), 32'd2);
        check_value("sf_head_rob", 32'(head_rob_index), 32'd12);

        // Wrap: 8 saves, 6 frees, 4 saves
        do_reset();
        for (int i = 0; i < 8; i++) do_save(7'(10 + i));
        for (int i = 0; i < 6; i++) do_free(3'(i));
        for (int i = 0; i < 4; i++) do_save(7'(20 + i));
        check_value("wrap_save_index", 32'(save_index), 32'd4);
        check_value("wrap_count", 32'(checkpoint_count), 32'd6);
        check_value("wrap_head_index", 32'(head_index), 32'd6);
        check_value("wrap_head_rob", 32'(head_rob_index), 32'd16);
        check_value("wrap_tail_wrap_bit", 32'(dut.tail_ptr_r[3]), 32'd1);

        // Restore: head=2, count=5, restore_index=4 with a save
        do_reset();
        for (int i = 0; i < 7; i++) do_save(7'(30 + i));
        do_free(3'd0);
        do_free(3'd1);
        check_value("pre_rs_count", 32'(checkpoint_count), 32'd5);
        check_value("pre_rs_head", 32'(head_index), 32'd2);
        restore_valid  = 1'b1;
        restore_index  = 3'd4;
        save_valid     = 1'b1;
        save_rob_index = 7'd50;
        #1;
        check_value("rs_save_fire", 32'(save_fire), 32'd0);
        tick();
        idle_inputs();
        check_value("rs_count", 32'(checkpoint_count), 32'd2);
        check_value("rs_fire", 32'(restore_fire), 32'd1);
        check_value("rs_read_index", 32'(restore_read_index), 32'd4);
        check_value("rs_error", 32'(restore_error), 32'd0);
        check_value("rs_save_index", 32'(save_index), 32'd4);
        tick();
        check_value("rs_fire_pulse", 32'(restore_fire), 32'd0);

        // Restore error: head=2, count=2, restore_index=5
        restore_valid = 1'b1;
        restore_index = 3'd5;
        tick();
        idle_inputs();
        check_value("err_count", 32'(checkpoint_count), 32'd2);
        check_value("err_error", 32'(restore_error), 32'd1);
        check_value("err_fire", 32'(restore_fire), 32'd0);
        tick();
        check_value("err_pulse", 32'(restore_error), 32'd0);

        // Next save lands at slot 4
        save_valid     = 1'b1;
        save_rob_index = 7'd51;
        #1;
        check_value("post_rs_save_index", 32'(save_index), 32'd4);
        check_value("post_rs_save_fire", 32'(save_fire), 32'd1);
        tick();
        save_valid = 1'b0;
        check_value("post_rs_count", 32'(checkpoint_count), 32'd3);

        // head=2, count=3: restore 2 with free 2 -> empty, head stays 2
        restore_valid = 1'b1;
        restore_index = 3'd2;
        free_valid    = 1'b1;
        free_index    = 3'd2;
        tick();
        idle_inputs();
        check_value("rf0_count", 32'(checkpoint_count), 32'd0);
        check_value("rf0_head", 32'(head_index), 32'd2);
        check_value("rf0_fire", 32'(restore_fire), 32'd1);

        // head=2, count=3 again: restore 3 with free 2 -> empty, head 3
        for (int i = 0; i < 3; i++) do_save(7'(60 + i));
        check_value("rf1_pre_count", 32'(checkpoint_count), 32'd3);
        restore_valid = 1'b1;
        restore_index = 3'd3;
        free_valid    = 1'b1;
        free_index    = 3'd2;
        tick();
        idle_inputs();
        check_value("rf1_count", 32'(checkpoint_count), 32'd0);
        check_value("rf1_head", 32'(head_index), 32'd3);
        check_value("rf1_read_index", 32'(restore_read_index), 32'd3);

        // Reset asserted during an accepted restore
        do_save(7'd70);
        do_save(7'd71);
        check_value("rr_pre_count", 32'(checkpoint_count), 32'd2);
        restore_valid = 1'b1;
        restore_index = 3'd4;
        RST           = 1'b1;
        tick();
        RST = 1'b0;
        idle_inputs();
        check_value("rr_fire", 32'(restore_fire), 32'd0);
        check_value("rr_count", 32'(checkpoint_count), 32'd0);
        check_value("rr_head", 32'(head_index), 32'd0);
        check_value("rr_head_rob", 32'(head_rob_index), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
